// File: rtl/sha2_job_arbiter.sv
// sha2_job_arbiter: round-robin front end that time-shares one single-block
// SHA-256 wrapper among NREQ requesters and returns digests with the requester ID.
module sha2_job_arbiter #(
    parameter  int unsigned NREQ    = 4,
    parameter  int unsigned TIMEOUT = 1024,
    localparam int unsigned IDW     = $clog2(NREQ)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*448-1:0]  req_msg,
    input  logic [NREQ*64-1:0]   req_len,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [255:0]         rsp_digest,
    output logic                 rsp_error,
    output logic [447:0]         sha_plaintext,
    output logic [66:0]          sha_csr,
    input  logic [255:0]         sha_digest,
    input  logic [2:0]           sha_status,
    input  logic                 sha_regwrite,
    input  logic                 sha_csr_update,
    output logic                 busy
);

    localparam int unsigned MSGW = 448;
    localparam int unsigned LENW = 64;
    localparam int unsigned DGW  = 256;
    localparam int unsigned CNTW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    localparam logic [LENW-1:0] MAX_LEN  = LENW'(447);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);
    localparam logic [2:0]      ST_DONE  = 3'd1;

    logic [2:0]      state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            armed_q;
    logic [LENW-1:0] len_q, len_d;
    logic            start_q, start_d;
    logic            rsp_valid_d, rsp_error_d, busy_d;
    logic [IDW-1:0]  rsp_id_d;
    logic [DGW-1:0]  rsp_digest_d;
    logic [MSGW-1:0] plaintext_d;

    logic            gnt_found;
    logic [IDW-1:0]  gnt_idx;
    logic            take;
    logic [MSGW-1:0] gnt_msg;
    logic [LENW-1:0] gnt_len;

    // Round-robin search starting one past the last granted requester
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 1; k <= int'(NREQ); k++) begin
            if (!gnt_found && req_valid[(int'(ptr_q) + k) % int'(NREQ)]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'((int'(ptr_q) + k) % int'(NREQ));
            end
        end
    end

    // Accept is only offered in IDLE, and not in the first cycle out of reset
    assign take      = (state_q == S_IDLE) && armed_q && gnt_found;
    assign req_ready = take ? (NREQ'(1) << gnt_idx) : '0;
    assign gnt_msg   = req_msg[gnt_idx*MSGW +: MSGW];
    assign gnt_len   = req_len[gnt_idx*LENW +: LENW];
    assign sha_csr   = {len_q, start_q, 2'b00};

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        start_d      = 1'b0;
        plaintext_d  = sha_plaintext;
        rsp_valid_d  = rsp_valid;
        rsp_id_d     = rsp_id;
        rsp_digest_d = rsp_digest;
        rsp_error_d  = rsp_error;

        case (state_q)
            S_IDLE: begin
                if (take) begin
                    ptr_d       = gnt_idx;
                    rsp_id_d    = gnt_idx;
                    plaintext_d = gnt_msg;
                    len_d       = gnt_len;
                    cnt_d       = '0;
                    if (gnt_len > MAX_LEN) begin
                        // Oversized message: report error without touching the core
                        state_d      = S_RESP;
                        rsp_valid_d  = 1'b1;
                        rsp_error_d  = 1'b1;
                        rsp_digest_d = '0;
                    end else begin
                        state_d = S_START;
                        start_d = 1'b1;
                    end
                end
            end
            S_START: begin
                cnt_d   = cnt_q + CNTW'(1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNTW'(1);
                if (sha_regwrite) begin
                    rsp_digest_d = sha_digest;
                    rsp_error_d  = 1'b0;
                    state_d      = S_DONE;
                end else if (cnt_q >= CNT_LAST) begin
                    rsp_digest_d = '0;
                    rsp_error_d  = 1'b1;
                    rsp_valid_d  = 1'b1;
                    state_d      = S_RESP;
                end
            end
            S_DONE: begin
                cnt_d = cnt_q + CNTW'(1);
                // Digest already captured; a missing status strobe only delays the response
                if ((sha_csr_update && (sha_status == ST_DONE)) || (cnt_q >= CNT_LAST)) begin
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    plaintext_d = '0;
                    len_d       = '0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            ptr_q         <= IDW'(NREQ - 1);
            cnt_q         <= '0;
            armed_q       <= 1'b0;
            len_q         <= '0;
            start_q       <= 1'b0;
            sha_plaintext <= '0;
            rsp_valid     <= 1'b0;
            rsp_id        <= '0;
            rsp_digest    <= '0;
            rsp_error     <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            armed_q       <= 1'b1;
            len_q         <= len_d;
            start_q       <= start_d;
            sha_plaintext <= plaintext_d;
            rsp_valid     <= rsp_valid_d;
            rsp_id        <= rsp_id_d;
            rsp_digest    <= rsp_digest_d;
            rsp_error     <= rsp_error_d;
            busy          <= busy_d;
        end
    end

endmodule
